// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory controller.
package dmem_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Request control fields held from accept until the response is issued.
  typedef struct packed {
    logic       we;
    size_e      size;
    logic       uns;
    logic [1:0] off;
  } req_ctl_t;

  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Lanes k with lo <= k < hi.
  function automatic logic [LANES-1:0] lane_span(input logic [2:0] lo, input logic [2:0] hi);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      m[k] = (3'(k) >= lo) && (3'(k) < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: synchronous write, registered read with read enable.
module dmem_bank #(
  parameter int unsigned DEPTH_AW   = 10,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_AW-1:0]   addr,
  input  logic [BYTE_WIDTH-1:0] wdata,
  output logic [BYTE_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_AW;

  logic [BYTE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register holds its value when not enabled so beats can assemble across cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Little-endian byte/half/word data memory controller over four byte-lane banks.
// Define DMEM_MISALIGN_SPLIT_EN to execute word-crossing accesses in two beats; otherwise they error.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter              INIT_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned WORD_AW = ADDRESS_WIDTH - 2;

  state_e                  state;
  state_e                  next_state;
  req_ctl_t                ctl_q;
  logic [WORD_AW-1:0]      idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    rsp_load_q;

  logic                    capture_c;
  logic                    beat2_c;
  logic [LANES-1:0]        lane_en_c;
  logic                    rsp_valid_d;
  logic                    rsp_err_d;
  logic                    rsp_load_d;

  size_e                   req_size_c;
  logic [1:0]              req_off_c;
  logic [2:0]              req_end_c;
  logic                    req_cross_c;

  logic                    we_sel_c;
  logic [1:0]              woff_c;
  logic [DATA_WIDTH-1:0]   wsrc_c;
  logic [WORD_AW-1:0]      bank_addr_c;
  logic [BYTE_WIDTH-1:0]   lane_wdata_c [LANES];
  logic [BYTE_WIDTH-1:0]   lane_rdata   [LANES];
  logic [DATA_WIDTH-1:0]   raw_c;
  logic [DATA_WIDTH-1:0]   ext_c;

  assign req_size_c  = size_e'(req_size);
  assign req_off_c   = req_addr[1:0];
  assign req_end_c   = 3'({1'b0, req_off_c}) + size_bytes(req_size_c);
  assign req_cross_c = (req_end_c > 3'd4);

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [2:0] q_end2_c;
  assign q_end2_c = 3'({1'b0, ctl_q.off}) + size_bytes(ctl_q.size) - 3'd4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, lane enables and response qualifiers for the coming edge.
  always_comb begin
    next_state  = state;
    capture_c   = 1'b0;
    beat2_c     = 1'b0;
    lane_en_c   = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_load_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          capture_c   = 1'b1;
          rsp_valid_d = 1'b1;
          if (req_size_c == SZ_RSVD) begin
            rsp_err_d = 1'b1;
          end else if (req_cross_c) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            lane_en_c   = lane_span({1'b0, req_off_c}, req_end_c);
            rsp_valid_d = 1'b0;
            next_state  = ST_SPLIT;
`else
            rsp_err_d   = 1'b1;
`endif
          end else begin
            lane_en_c  = lane_span({1'b0, req_off_c}, req_end_c);
            rsp_load_d = !req_we;
          end
        end
      end
      ST_SPLIT: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        beat2_c     = 1'b1;
        lane_en_c   = lane_span(3'd0, q_end2_c);
        rsp_valid_d = 1'b1;
        rsp_load_d  = !ctl_q.we;
`endif
        next_state  = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Beat 2 replays the captured request against the following word.
  always_comb begin
    we_sel_c    = beat2_c ? ctl_q.we  : req_we;
    woff_c      = beat2_c ? ctl_q.off : req_off_c;
    wsrc_c      = beat2_c ? wdata_q   : req_wdata;
    bank_addr_c = beat2_c ? WORD_AW'(idx_q + 1'b1) : req_addr[ADDRESS_WIDTH-1:2];
    for (int k = 0; k < LANES; k++) begin
      lane_wdata_c[k] = wsrc_c[BYTE_WIDTH*(2'(2'(k) - woff_c)) +: BYTE_WIDTH];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dmem_bank #(
      .DEPTH_AW   (WORD_AW),
      .BYTE_WIDTH (BYTE_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_en_c[g] & we_sel_c),
      .re    (lane_en_c[g] & ~we_sel_c),
      .addr  (bank_addr_c),
      .wdata (lane_wdata_c[g]),
      .rdata (lane_rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_load_q <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
      req_ready  <= (next_state == ST_IDLE);
      if (capture_c) begin
        ctl_q   <= '{we: req_we, size: req_size_c, uns: req_unsigned, off: req_off_c};
        idx_q   <= req_addr[ADDRESS_WIDTH-1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // Rotate lane bytes back into access order, then extend to the word.
  always_comb begin
    raw_c = '0;
    for (int k = 0; k < LANES; k++) begin
      raw_c[BYTE_WIDTH*(2'(2'(k) - ctl_q.off)) +: BYTE_WIDTH] = lane_rdata[k];
    end
    case (ctl_q.size)
      SZ_BYTE: ext_c = ctl_q.uns ? DATA_WIDTH'(raw_c[BYTE_WIDTH-1:0])
                     : {{(DATA_WIDTH-BYTE_WIDTH){raw_c[BYTE_WIDTH-1]}}, raw_c[BYTE_WIDTH-1:0]};
      SZ_HALF: ext_c = ctl_q.uns ? DATA_WIDTH'(raw_c[2*BYTE_WIDTH-1:0])
                     : {{(DATA_WIDTH-2*BYTE_WIDTH){raw_c[2*BYTE_WIDTH-1]}}, raw_c[2*BYTE_WIDTH-1:0]};
      default: ext_c = raw_c;
    endcase
    rsp_rdata = (rsp_valid && rsp_load_q) ? ext_c : '0;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed requests push expected responses, a monitor checks them.
module tb_data_mem_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int PERIOD = 10;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  typedef struct {
    int            id;
    logic          err;
    logic [DW-1:0] rdata;
    longint        t;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nfail = 0;
  int   nid = 0;

  always #(PERIOD/2) clk = ~clk;

  data_mem_ctrl #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .BYTE_WIDTH    (8),
    .INIT_FILE     ("")
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; lat is the expected accept-to-response latency in cycles.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic exp_err, input logic [DW-1:0] exp_rdata, input int lat);
    int   guard;
    exp_t e;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("ready_before_req%0d", nid), 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.id    = nid;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    e.t     = longint'($time) + longint'(PERIOD * lat);
    nid++;
    sb.push_back(e);
    @(negedge clk);
    if (lat == 2) begin
      req_we       = ~we;
      req_size     = W;
      req_unsigned = ~uns;
      req_addr     = ~addr;
      req_wdata    = ~wdata;
      check($sformatf("ready_in_split%0d", e.id), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0b rdata=0x%08h, expected no response",
                   rsp_err, rsp_rdata);
        end else begin
          e = sb.pop_front();
          check($sformatf("rsp%0d_err", e.id), 64'(rsp_err), 64'(e.err));
          check($sformatf("rsp%0d_rdata", e.id), 64'(rsp_rdata), 64'(e.rdata));
          check($sformatf("rsp%0d_time", e.id), 64'($time), 64'(e.t));
        end
      end
    end
  end

  initial begin
    #(PERIOD * 5000);
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    #(PERIOD * 2 + 2);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    send(1, W, 0, 12'h010, 32'hDEADBEEF, 0, 32'h0, 1);
    send(0, W, 0, 12'h010, 32'h0, 0, 32'hDEADBEEF, 1);
    send(0, B, 0, 12'h013, 32'h0, 0, 32'hFFFFFFDE, 1);
    send(0, H, 1, 12'h012, 32'h0, 0, 32'h0000DEAD, 1);
    send(0, H, 0, 12'h011, 32'h0, 0, 32'hFFFFADBE, 1);
    send(0, B, 1, 12'h010, 32'h0, 0, 32'h000000EF, 1);
    send(1, B, 0, 12'h011, 32'hFFFFFF55, 0, 32'h0, 1);
    send(1, H, 0, 12'h012, 32'hAAAA1234, 0, 32'h0, 1);
    send(0, W, 0, 12'h010, 32'h0, 0, 32'h123455EF, 1);

    send(1, W, 0, 12'h020, 32'h01020304, 0, 32'h0, 1);
    send(1, R, 0, 12'h020, 32'hCAFEBABE, 1, 32'h0, 1);
    send(0, R, 1, 12'h021, 32'h0, 1, 32'h0, 1);
    send(0, W, 0, 12'h020, 32'h0, 0, 32'h01020304, 1);

    send(1, W, 0, 12'h0FC, 32'hA0B0C0D0, 0, 32'h0, 1);
    send(1, W, 0, 12'h100, 32'h90807060, 0, 32'h0, 1);
    send(1, W, 0, 12'hFFC, 32'h01234567, 0, 32'h0, 1);
    send(1, W, 0, 12'h000, 32'h89ABCDEF, 0, 32'h0, 1);
`ifdef DMEM_MISALIGN_SPLIT_EN
    send(1, W, 0, 12'h0FE, 32'h11223344, 0, 32'h0, 2);
    send(0, W, 0, 12'h0FE, 32'h0, 0, 32'h11223344, 2);
    send(0, B, 1, 12'h100, 32'h0, 0, 32'h00000022, 1);
    send(0, W, 0, 12'h0FC, 32'h0, 0, 32'h3344C0D0, 1);
    send(0, W, 0, 12'h100, 32'h0, 0, 32'h90801122, 1);
    send(0, H, 0, 12'h0FF, 32'h0, 0, 32'h00002233, 2);
    send(1, H, 0, 12'hFFF, 32'h0000A55A, 0, 32'h0, 2);
    send(0, B, 1, 12'hFFF, 32'h0, 0, 32'h0000005A, 1);
    send(0, B, 1, 12'h000, 32'h0, 0, 32'h000000A5, 1);
    send(0, H, 0, 12'hFFF, 32'h0, 0, 32'hFFFFA55A, 2);
    send(0, W, 0, 12'hFFC, 32'h0, 0, 32'h5A234567, 1);
    send(0, W, 0, 12'h000, 32'h0, 0, 32'h89ABCDA5, 1);
`else
    send(1, W, 0, 12'h0FE, 32'h11223344, 1, 32'h0, 1);
    send(0, W, 0, 12'h0FE, 32'h0, 1, 32'h0, 1);
    send(0, B, 1, 12'h100, 32'h0, 0, 32'h00000060, 1);
    send(0, W, 0, 12'h0FC, 32'h0, 0, 32'hA0B0C0D0, 1);
    send(1, H, 0, 12'hFFF, 32'h0000A55A, 1, 32'h0, 1);
    send(0, B, 1, 12'hFFF, 32'h0, 0, 32'h00000001, 1);
    send(0, B, 1, 12'h000, 32'h0, 0, 32'h000000EF, 1);
`endif

    // Reset while a crossing store is in flight.
    send(1, W, 0, 12'h0FC, 32'hA0B0C0D0, 0, 32'h0, 1);
    send(1, W, 0, 12'h100, 32'h90807060, 0, 32'h0, 1);
    repeat (2) @(negedge clk);
    check("drain_before_reset", 64'(sb.size()), 64'd0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = W;
    req_addr  = 12'h0FE;
    req_wdata = 32'h11223344;
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("split_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    #5;
    rst_n = 1'b1;
    @(negedge clk);
    check("split_reset_ready", 64'(req_ready), 64'd1);
    check("split_reset_no_rsp", 64'(rsp_valid), 64'd0);
`ifdef DMEM_MISALIGN_SPLIT_EN
    send(0, W, 0, 12'h0FC, 32'h0, 0, 32'h3344C0D0, 1);
`else
    send(0, W, 0, 12'h0FC, 32'h0, 0, 32'hA0B0C0D0, 1);
`endif
    send(0, W, 0, 12'h100, 32'h0, 0, 32'h90807060, 1);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 12: byte-address width; total capacity 2**ADDRESS_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default 32: word width; fixed at 32 in this generation (4 byte lanes).
REQ-003 Parameter BYTE_WIDTH, default 8: lane width.
REQ-004 Parameter INIT_FILE, default "": hex preload file; empty means no preload.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when req_valid && req_ready at posedge.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-012 req_addr  input  ADDRESS_WIDTH  byte address.
REQ-013 req_wdata  input  DATA_WIDTH  store data, right-justified.
REQ-014 rsp_valid  output  1  one-cycle response pulse, issued for every accepted request.
REQ-015 rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  qualified by rsp_valid; request not performed.

Function
REQ-017 Storage: little-endian byte-addressed memory; byte at address A+k holds bits [8k+7:8k] of the access.
REQ-018 Word index = addr[AW-1:2]; lane offset = addr[1:0]; n = 1/2/4 bytes per req_size.
REQ-019 Crossing access: offset + n > 4; all other accesses, including misaligned half at offset 1, are single-beat.
REQ-020 FSM states IDLE and SPLIT; req_ready = 1 in IDLE, 0 in SPLIT.
REQ-021 Single-beat request accepted in IDLE: store lanes written at the accept edge; load lanes captured at the accept edge.
REQ-022 For a single-beat request, rsp_valid = 1 in the cycle after the accept edge; latency 1; state remains IDLE.
REQ-023 Crossing request, beat 1 (accept edge): lanes offset..3 of the word index; IDLE -> SPLIT.
REQ-024 Crossing request, beat 2 (next edge): lanes 0..offset+n-5 of word index+1; SPLIT -> IDLE; rsp_valid in the following cycle; latency 2.
REQ-025 Word index+1 wraps modulo 2**(AW-2); top-word crossing touches word 0.
REQ-026 Loads: rsp_rdata = assembled n bytes, sign- or zero-extended per req_unsigned captured at accept.
REQ-027 Stores: only the n addressed bytes change; other lanes keep their values.
REQ-028 req_size = 11: no memory change; rsp_valid after 1 cycle with rsp_err = 1 and rsp_rdata = 0.
REQ-029 Request fields are registered at accept; input changes during SPLIT are ignored.
REQ-030 Back-to-back single-beat requests are sustained at one per cycle.

Reset
REQ-031 rst_n low: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1 after release.
REQ-032 Memory contents are not reset.
REQ-033 Reset asserted in SPLIT: beat-1 store bytes remain written, beat 2 is discarded, and no response is issued.

Configuration
REQ-034 Macro DMEM_MISALIGN_SPLIT_EN defined: crossing accesses execute per REQ-023..024.
REQ-035 Macro DMEM_MISALIGN_SPLIT_EN undefined: crossing accesses produce no memory change and a 1-cycle response with rsp_err = 1 and rsp_rdata = 0; the SPLIT state is absent.

Structure
REQ-036 Package dmem_pkg holds the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), the FSM state enum and LANES = 4.
REQ-037 Sub-module dmem_bank: one byte lane with depth 2**(AW-2), synchronous write-enable, and registered read; it is instantiated 4 times.

Verification
REQ-038 Store word 0xDEADBEEF at addr 0x010, then load word at 0x010 -> 0xDEADBEEF; load byte signed at 0x013 -> 0xFFFFFFDE.
REQ-039 Load half unsigned at 0x012 -> 0x0000DEAD; load half at 0x011 -> single beat, 0xFFFFADBE signed.
REQ-040 With the macro defined, store word 0x11223344 at 0x0FE -> two beats, req_ready low 1 cycle; load word at 0x0FE -> 0x11223344; byte 0x100 = 0x22.
REQ-041 Top-address crossing: store half 0xA55A at 0xFFF -> byte 0xFFF = 0x5A, byte 0x000 = 0xA5.
REQ-042 req_size = 11 store at 0x020 -> rsp_err = 1, memory at 0x020 unchanged; without the macro, a word load at 0x0FE -> rsp_err = 1.
REQ-043 rst_n pulsed low in SPLIT of a store at 0x0FE -> no rsp_valid; bytes 0x0FE..0x0FF written; 0x100..0x101 unchanged.
